// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster timing, sync bundle type and test-bar colours.
package vga_timing_pkg;

   localparam int DEF_H_VISIBLE  = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_VISIBLE  = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;
   localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_PIPE_DEPTH = 2;

   // Width of one colour bar in the test pattern.
   localparam int BAR_W = 80;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
   } sync_t;

   // Idle raster state: both syncs inactive (high) and blanked.
   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

   // Classic colour bars, left to right.
   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage enabled shift register (DEPTH=0 is a wire) with async reset value.
module sync_delay_line #(
   parameter int             DEPTH   = 2,
   parameter int             W       = 3,
   parameter logic [W-1:0]   RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // At least one stage is always built so the ports stay in use; it is bypassed when DEPTH is 0.
   localparam int N = (DEPTH == 0) ? 1 : DEPTH;

   logic [W-1:0] stage [N];

   // Shift one position per enabled step; reset loads the idle value into every stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = (DEPTH == 0) ? d : stage[N-1];

endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: raster counters, sync/blank re-alignment to RGB and VGA pin register; VGA_TEST_PATTERN_EN adds colour bars.
module vga_scan_out
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = DEF_H_VISIBLE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_VISIBLE  = DEF_V_VISIBLE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       pixel_en,
`ifdef VGA_TEST_PATTERN_EN
   input  logic       test_mode,
`endif
   input  logic [7:0] Red,
   input  logic [7:0] Green,
   input  logic [7:0] Blue,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       frame_start,
   output logic       vblank_start,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_VB   = 10'(V_VISIBLE - 1);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        h_last;
   logic        v_last;
   sync_t       raw;
   sync_t       dly;
   logic [23:0] rgb_src;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);
   assign DrawX  = h_cnt;
   assign DrawY  = v_cnt;

   // Sync and blank as seen by the pixel currently being issued on DrawX/DrawY.
   assign raw = '{
      hs:    !((h_cnt >= HS_ON) && (h_cnt <= HS_OFF)),
      vs:    !((v_cnt >= VS_ON) && (v_cnt <= VS_OFF)),
      blank: (h_cnt >= H_VIS) || (v_cnt >= V_VIS)
   };

   // Raster position: horizontal advances per pixel step, vertical on each line wrap.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pixel_en) begin
         h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
         if (h_last) v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end
   end

   // One-Clk strobes raised by the step that lands on (0,0) or on the first vblank line.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         frame_start  <= pixel_en && h_last && v_last;
         vblank_start <= pixel_en && h_last && (v_cnt == V_VB);
      end
   end

   // Hold timing back by the colour lookup latency so it lines up with the returned RGB.
   sync_delay_line #(
      .DEPTH   (PIPE_DEPTH),
      .W       ($bits(sync_t)),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk   (Clk),
      .rst_n (Reset_n),
      .en    (pixel_en),
      .d     (raw),
      .q     (dly)
   );

`ifdef VGA_TEST_PATTERN_EN
   logic [9:0] x_dly;
   logic [2:0] bar;

   sync_delay_line #(
      .DEPTH   (PIPE_DEPTH),
      .W       (10),
      .RST_VAL ('0)
   ) u_x_dly (
      .clk   (Clk),
      .rst_n (Reset_n),
      .en    (pixel_en),
      .d     (h_cnt),
      .q     (x_dly)
   );

   assign bar     = 3'((x_dly >= 10'(8 * BAR_W)) ? 10'd7 : x_dly / 10'(BAR_W));
   assign rgb_src = test_mode ? BAR_RGB[bar] : {Red, Green, Blue};
`else
   assign rgb_src = {Red, Green, Blue};
`endif

   // Pin register: delayed syncs plus colour, forced black while blanked.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         VGA_HS                <= 1'b1;
         VGA_VS                <= 1'b1;
         VGA_BLANK_N           <= 1'b0;
         {VGA_R, VGA_G, VGA_B} <= '0;
      end else if (pixel_en) begin
         VGA_HS                <= dly.hs;
         VGA_VS                <= dly.vs;
         VGA_BLANK_N           <= !dly.blank;
         {VGA_R, VGA_G, VGA_B} <= dly.blank ? 24'h0 : rgb_src;
      end
   end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: random pixel_en/colour stimulus on a full-size and a shrunken-raster instance, checked against a step-count model.
module tb_vga_scan_out;

   // Shrunken raster so whole frames fit in the run; direct (zero-depth) alignment path.
   localparam int SHV = 16, SHFP = 4, SHS = 6, SHBP = 4;
   localparam int SVV = 12, SVFP = 2, SVS = 2, SVBP = 3;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        fs;
      logic        vb;
      logic        hs;
      logic        vs;
      logic        bn;
      logic [23:0] rgb;
   } pins_t;

   localparam logic [23:0] BARS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       pixel_en;
   logic [7:0] Red, Green, Blue;
`ifdef VGA_TEST_PATTERN_EN
   logic       test_mode;
`endif

   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_fs, a_vb, a_hs, a_vs, a_bn;
   logic       b_fs, b_vb, b_hs, b_vs, b_bn;
   logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

   int          m;
   logic [23:0] cc  [0:65535];
   bit          tmh [0:65535];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 Clk = ~Clk;

   vga_scan_out u_full (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .pixel_en     (pixel_en),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode    (test_mode),
`endif
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .DrawX        (a_x),
      .DrawY        (a_y),
      .frame_start  (a_fs),
      .vblank_start (a_vb),
      .VGA_HS       (a_hs),
      .VGA_VS       (a_vs),
      .VGA_BLANK_N  (a_bn),
      .VGA_R        (a_r),
      .VGA_G        (a_g),
      .VGA_B        (a_b)
   );

   vga_scan_out #(
      .H_VISIBLE (SHV), .H_FP (SHFP), .H_SYNC (SHS), .H_BP (SHBP),
      .V_VISIBLE (SVV), .V_FP (SVFP), .V_SYNC (SVS), .V_BP (SVBP),
      .PIPE_DEPTH (0)
   ) u_small (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .pixel_en     (pixel_en),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode    (test_mode),
`endif
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .DrawX        (b_x),
      .DrawY        (b_y),
      .frame_start  (b_fs),
      .vblank_start (b_vb),
      .VGA_HS       (b_hs),
      .VGA_VS       (b_vs),
      .VGA_BLANK_N  (b_bn),
      .VGA_R        (b_r),
      .VGA_G        (b_g),
      .VGA_B        (b_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t step=%0d: got %h, expected %h", tag, $time, m, got, exp);
      end
   endtask

   // Expected pins after m pixel steps since reset. Pixel k = m-d-1 is on the pins,
   // coloured by whatever was presented on the step just before the pins were loaded.
   function automatic pins_t model(input int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, d,
                                   input int mm, input bit edge_now,
                                   input logic [23:0] c, input bit tm);
      int    ht = hv + hfp + hsw + hbp;
      int    vt = vv + vfp + vsw + vbp;
      int    f  = ht * vt;
      int    k  = mm - d - 1;
      int    px, py;
      pins_t p;
      p.x  = 10'(mm % ht);
      p.y  = 10'((mm / ht) % vt);
      p.fs = edge_now && (mm % f == 0);
      p.vb = edge_now && (mm % f == vv * ht);
      if (k < 0) begin
         p.hs  = 1'b1;
         p.vs  = 1'b1;
         p.bn  = 1'b0;
         p.rgb = 24'h0;
      end else begin
         px    = k % ht;
         py    = (k / ht) % vt;
         p.hs  = !(px >= hv + hfp && px < hv + hfp + hsw);
         p.vs  = !(py >= vv + vfp && py < vv + vfp + vsw);
         p.bn  = (px < hv) && (py < vv);
         p.rgb = !p.bn ? 24'h0 : tm ? BARS[px / 80] : c;
      end
      return p;
   endfunction

   task automatic check_all(input bit edge_now);
      logic [23:0] c  = (m > 0) ? cc[m-1]  : 24'h0;
      bit          tm = (m > 0) ? tmh[m-1] : 1'b0;
      pins_t pa = model(640, 16, 96, 48, 480, 10, 2, 33, 2, m, edge_now, c, tm);
      pins_t pb = model(SHV, SHFP, SHS, SHBP, SVV, SVFP, SVS, SVBP, 0, m, edge_now, c, tm);
      check("full DrawX",        32'(a_x),  32'(pa.x));
      check("full DrawY",        32'(a_y),  32'(pa.y));
      check("full frame_start",  32'(a_fs), 32'(pa.fs));
      check("full vblank_start", 32'(a_vb), 32'(pa.vb));
      check("full VGA_HS",       32'(a_hs), 32'(pa.hs));
      check("full VGA_VS",       32'(a_vs), 32'(pa.vs));
      check("full VGA_BLANK_N",  32'(a_bn), 32'(pa.bn));
      check("full RGB",          32'({a_r, a_g, a_b}), 32'(pa.rgb));
      check("small DrawX",        32'(b_x),  32'(pb.x));
      check("small DrawY",        32'(b_y),  32'(pb.y));
      check("small frame_start",  32'(b_fs), 32'(pb.fs));
      check("small vblank_start", 32'(b_vb), 32'(pb.vb));
      check("small VGA_HS",       32'(b_hs), 32'(pb.hs));
      check("small VGA_VS",       32'(b_vs), 32'(pb.vs));
      check("small VGA_BLANK_N",  32'(b_bn), 32'(pb.bn));
      check("small RGB",          32'({b_r, b_g, b_b}), 32'(pb.rgb));
   endtask

   // One Clk cycle: present inputs, let the posedge happen, check at the following negedge.
   task automatic step(input bit pe, input bit tm);
      cc[m]  = 24'($urandom);
      tmh[m] = tm;
      {Red, Green, Blue} = cc[m];
`ifdef VGA_TEST_PATTERN_EN
      test_mode = tm;
`endif
      pixel_en = pe;
      @(negedge Clk);
      if (pe) m++;
      check_all(pe);
   endtask

   task automatic do_reset();
      Reset_n  = 1'b0;
      pixel_en = 1'b0;
      m = 0;
      #1;
      check_all(1'b0);
      repeat (3) @(negedge Clk);
      check_all(1'b0);
      Reset_n = 1'b1;
   endtask

   function automatic bit pick_tm();
`ifdef VGA_TEST_PATTERN_EN
      return bit'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      Reset_n  = 1'b1;
      pixel_en = 1'b0;
      {Red, Green, Blue} = '0;
`ifdef VGA_TEST_PATTERN_EN
      test_mode = 1'b0;
`endif
      #2;
      do_reset();
      // Nominal one-in-two strobe across the first line wrap and beyond.
      for (int i = 0; i < 3400; i++) step(bit'(i % 2), 1'b0);
      // Reset mid-line at h_cnt=300 of the full raster.
      for (int i = 0; i < 1700 && (m % 800) != 300; i++) step(bit'(i % 2), 1'b0);
      check("reset point DrawX", 32'(a_x), 32'd300);
      do_reset();
      // Random strobe density, stalls and full-rate bursts.
      for (int i = 0; i < 36000; i++) begin
         if (i == 10000)
            for (int j = 0; j < 50; j++) step(1'b0, pick_tm());
         if (i >= 20000 && i < 24000)
            step(1'b1, pick_tm());
         else
            step(bit'($urandom_range(0, 99) < 60), pick_tm());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_scan_out.md
Name: vga_scan_out

Overview:
- Display-side endpoint of the pixel path. It generates the 640x480@60 raster scan and drives DrawX/DrawY to the sprite ROM and color mapping logic.
- It accepts the resulting 24-bit RGB after a fixed lookup latency. It re-aligns HS, VS and blank with that data and drives the VGA DAC pins.
- It also provides frame and vblank strobes for game-state update logic (character motion, HP bars, KO overlay).

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- PIPE_DEPTH, 2, pixel_en steps from DrawX/DrawY change to valid Red/Green/Blue input (range 0..7)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- pixel_en  in  1  pixel strobe, one Clk cycle in two
- Red, Green, Blue  in  8 each  colour for the pixel issued PIPE_DEPTH pixel_en steps earlier
- DrawX  out  10  current horizontal count
- DrawY  out  10  current vertical count
- frame_start  out  1  one-Clk pulse at raster (0,0)
- vblank_start  out  1  one-Clk pulse when DrawY enters V_VISIBLE
- VGA_HS, VGA_VS  out  1  active-low sync, aligned to RGB
- VGA_BLANK_N  out  1  high during visible pixels, aligned to RGB
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour

Behaviour:
- Reset: Clk is the single clock; Reset_n is asynchronous and active-low. Reset asserted mid-frame aborts immediately, and the scan restarts at (0,0) after deassertion.
- Reset values:
  - counters = 0, so DrawX = DrawY = 0
  - VGA_HS = VGA_VS = 1
  - VGA_BLANK_N = 0
  - VGA_R/G/B = 0
  - frame_start = vblank_start = 0
  - delay line filled with {hs=1, vs=1, blank=1}
- Counters: h_cnt wraps at H_TOTAL-1 (799) to 0; v_cnt increments only on that wrap and wraps at V_TOTAL-1 (524). Both advance only on Clk edges with pixel_en=1 and hold otherwise. DrawX = h_cnt and DrawY = v_cnt, both registered.
- Raw timing, computed from the current counters:
  - hs_raw = 0 iff h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [656,751]
  - vs_raw = 0 iff v_cnt in [490,491]
  - blank_raw = (h_cnt >= 640) or (v_cnt >= 480)
- Alignment: {hs, vs, blank} passes through a PIPE_DEPTH-stage shift register that shifts on pixel_en. PIPE_DEPTH = 0 means a direct path.
- Output register, updated on pixel_en:
  - VGA_HS, VGA_VS, VGA_BLANK_N = ~blank take the delayed values
  - VGA_R/G/B = delayed blank ? 0 : Red/Green/Blue
- Total latency: DrawX/DrawY change to pin change is PIPE_DEPTH+1 pixel_en steps.
- frame_start is high for exactly the one Clk cycle after the pixel_en edge that moves the counters from (799,524) to (0,0).
- vblank_start is high for exactly the one Clk cycle after the pixel_en edge that moves the counters from (799,479) to (0,480).
- If pixel_en stays low, all state freezes and the strobes stay 0.
- pixel_en held high every cycle is legal (scan runs 2x) and needs no special handling.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, the Red/Green/Blue inputs are ignored. Colour instead comes from the delayed X position (X delayed alongside sync), as 8 bars of 80 px.
  - Bar colours, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Blanking still forces 0.
- When undefined: the test_mode port does not exist, and the pass-through logic is the only colour source.

Decomposition:
- Package vga_timing_pkg holds:
  - the default H/V timing constants and derived H_TOTAL = 800, V_TOTAL = 525
  - typedef struct packed {logic hs; logic vs; logic blank;} sync_t
  - the test-bar colour constant array
- One sub-module, sync_delay_line: a parameterized PIPE_DEPTH shift register of sync_t with a shift enable and asynchronous reset value.

Test Plan:
- Reset: assert Reset_n=0 mid-line at h_cnt=300 -> next cycle all outputs are at reset values. Release, then 800 pixel_en -> DrawX returns to 0 and DrawY=1.
- Sync timing: free-run one frame with PIPE_DEPTH=2 -> VGA_HS low for exactly 96 pixel_en per line, falling 3 steps after DrawX=656. VGA_VS low for exactly 1600 pixel_en, starting 3 steps after DrawY=490 at DrawX=0.
- Alignment: feed Red = DrawX[7:0] delayed 2 steps -> VGA_R equals the pixel's own X. First visible pixel VGA_R=00 and last is 7F (639 mod 256). VGA_R=0 throughout blanking.
- Strobes: run 2 frames -> frame_start pulses exactly once per 420000 pixel_en, one Clk wide. vblank_start pulses once per frame, when DrawY becomes 480 and DrawX is 0.
- Stall: hold pixel_en=0 for 50 cycles mid-line -> DrawX, DrawY and all VGA pins are unchanged and no strobes fire.
- Test pattern (VGA_TEST_PATTERN_EN defined, test_mode=1): at visible X=85 the pins read FFFF00. At X=639 they read 000000. With Red/Green/Blue tied to AA, the input has no effect.
